// File: rtl/ssd_scan_controller.sv
// Seven-segment display engine: loads a binary value, converts it to BCD with a
// sequential double-dabble engine and scans N multiplexed active-low digits.
module ssd_scan_controller #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned VALUE_W   = 14,
  parameter int unsigned REFRESH_W = 18,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [VALUE_W-1:0]  Value,
  input  logic                Load,
  input  logic [N_DIGITS-1:0] Dp_mask,
  output logic                Busy,
  output logic                Overflow,
  output logic [N_DIGITS-1:0] An,
  output logic [7:0]          Seg
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(VALUE_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic {IDLE, CONVERT} state_e;

  state_e               state_q, state_d;
  logic [VALUE_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [VALUE_W-1:0]   pend_val_q, pend_val_d;
  logic [REFRESH_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DIGITS-1:0]  an_q, an_d;
  logic [7:0]           seg_q, seg_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_shift;
  logic [VALUE_W-1:0]   bin_shift;
  logic                 carry;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // One double-dabble iteration; the bit leaving the BCD MSB marks overflow.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned d = 0; d < N_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    {carry, bcd_shift, bin_shift} = {bcd_adj, bin_q, 1'b0};
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q;
    disp_d       = disp_q;
    ovf_d        = ovf_q;
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    case (state_q)
      IDLE: begin
        if (Load) begin
          bin_d    = Value;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_INIT;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d    = bcd_shift;
        bin_d    = bin_shift;
        sticky_d = sticky_q | carry;
        cnt_d    = cnt_q - CNT_W'(1);
        if (Load) begin
          pend_valid_d = 1'b1;
          pend_val_d   = Value;
        end
        if (cnt_q == CNT_W'(1)) begin
          disp_d       = bcd_shift;
          ovf_d        = sticky_q | carry;
          pend_valid_d = 1'b0;
          // A Load on the commit edge is newer than the pending slot.
          if (Load || pend_valid_q) begin
            bin_d    = Load ? Value : pend_val_q;
            bcd_d    = '0;
            sticky_d = 1'b0;
            cnt_d    = CNT_INIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [N_DIGITS-1:0] zero_run;
  logic                run;
  logic [3:0]          digit;
  logic                blank;
  logic [6:0]          seg7;

  always_comb begin
    scan_d = scan_q + REFRESH_W'(1);
    idx_d  = idx_q;
    if (scan_q == '1) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // zero_run[i]: digit i and every more-significant digit are zero.
    run      = 1'b1;
    zero_run = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      run = run & (disp_q[4*(N_DIGITS-1-i) +: 4] == 4'd0);
      zero_run[N_DIGITS-1-i] = run;
    end

    digit = disp_q[4*int'(idx_q) +: 4];
    blank = (BLANK_LZ != 0) && (idx_q != '0) && zero_run[idx_q];
    if (ovf_q)      seg7 = 7'b1111110;
    else if (blank) seg7 = 7'b1111111;
    else            seg7 = seg_code(digit);
    seg_d = {seg7, ~Dp_mask[idx_q]};
    an_d  = ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
      disp_q       <= '0;
      ovf_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      scan_q       <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      seg_q        <= '1;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      sticky_q     <= sticky_d;
      disp_q       <= disp_d;
      ovf_q        <= ovf_d;
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      scan_q       <= scan_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign Busy     = (state_q == CONVERT);
  assign Overflow = ovf_q;
  assign An       = an_q;
  assign Seg      = seg_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench for ssd_scan_controller: one instance with leading-zero
// blanking, one without, driven from the same stimulus.
module tb_ssd_scan_controller;

  localparam int VW = 14;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Load;
  logic [VW-1:0] Value;
  logic [3:0]    Dp_mask;
  logic          busy_a, ovf_a, busy_b, ovf_b;
  logic [3:0]    an_a, an_b;
  logic [7:0]    seg_a, seg_b;

  always #5 CLK = ~CLK;

  ssd_scan_controller #(.N_DIGITS(4), .VALUE_W(14), .REFRESH_W(2), .BLANK_LZ(1)) dut (
    .CLK(CLK), .Reset(Reset), .Value(Value), .Load(Load), .Dp_mask(Dp_mask),
    .Busy(busy_a), .Overflow(ovf_a), .An(an_a), .Seg(seg_a)
  );

  ssd_scan_controller #(.N_DIGITS(4), .VALUE_W(14), .REFRESH_W(2), .BLANK_LZ(0)) dut_nb (
    .CLK(CLK), .Reset(Reset), .Value(Value), .Load(Load), .Dp_mask(Dp_mask),
    .Busy(busy_b), .Overflow(ovf_b), .An(an_b), .Seg(seg_b)
  );

  typedef logic [3:0][7:0] segs_t;
  typedef struct {
    logic [VW-1:0] value;
    logic [3:0]    dp;
    segs_t         lz;
    segs_t         nb;
    logic          ovf;
  } vec_t;
  typedef struct {
    segs_t lz;
    segs_t nb;
    logic  ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] an);
    case (an)
      4'b1110: idx_of = 0;
      4'b1101: idx_of = 1;
      4'b1011: idx_of = 2;
      4'b0111: idx_of = 3;
      default: idx_of = -1;
    endcase
  endfunction

  task automatic scan(input int ncyc, output segs_t sa, output segs_t sb,
                      output logic [3:0] seen_a, output logic [3:0] seen_b,
                      output logic onehot_ok);
    int ia, ib;
    sa = '1; sb = '1; seen_a = '0; seen_b = '0; onehot_ok = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      ia = idx_of(an_a);
      ib = idx_of(an_b);
      if (ia >= 0) begin sa[ia[1:0]] = seg_a; seen_a[ia[1:0]] = 1'b1; end
      else onehot_ok = 1'b0;
      if (ib >= 0) begin sb[ib[1:0]] = seg_b; seen_b[ib[1:0]] = 1'b1; end
      else onehot_ok = 1'b0;
    end
  endtask

  task automatic check_display(input string nm, input segs_t lz, input segs_t nb);
    segs_t sa, sb;
    logic [3:0] sna, snb;
    logic ok;
    scan(16, sa, sb, sna, snb, ok);
    check({nm, "_onehot"}, 32'(ok), 32'd1);
    check({nm, "_seen"}, {24'd0, sna, snb}, 32'h0000_00FF);
    check({nm, "_seg_lz"}, sa, lz);
    check({nm, "_seg_nb"}, sb, nb);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_an"}, 32'({an_a, an_b}), 32'h0000_00FF);
    check({nm, "_seg"}, 32'({seg_a, seg_b}), 32'h0000_FFFF);
    check({nm, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
    check({nm, "_ovf"}, 32'({ovf_a, ovf_b}), 32'd0);
  endtask

  task automatic release_and_check(input string nm);
    Reset = 1'b1;
    @(negedge CLK);
    check({nm, "_first_an"}, 32'(an_a), 32'h0000_000E);
    check({nm, "_first_seg"}, 32'(seg_a), 32'h0000_0003);
    check({nm, "_busy"}, 32'(busy_a), 32'd0);
    check_display(nm, 32'hFFFF_FF03, 32'h0303_0303);
  endtask

  task automatic run_load(input string nm, input vec_t v);
    int   n;
    exp_t e;
    Dp_mask = v.dp;
    @(negedge CLK);
    Value = v.value;
    Load  = 1'b1;
    sb_q.push_back('{lz: v.lz, nb: v.nb, ovf: v.ovf});
    @(negedge CLK);
    Load = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check({nm, "_busy_len"}, 32'(n), 32'd14);
    if (sb_q.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      repeat (2) @(negedge CLK);
      check({nm, "_ovf"}, 32'({ovf_a, ovf_b}), {30'd0, e.ovf, e.ovf});
      check_display(nm, e.lz, e.nb);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    segs_t      s42;
    logic [3:0] seen42;
    int         busy_cnt;
    logic       saw1;
    exp_t       e;
    int         ia;

    vecs[0] = '{value: 14'd1234,  dp: 4'b0000, lz: 32'h9F25_0D99, nb: 32'h9F25_0D99, ovf: 1'b0};
    vecs[1] = '{value: 14'd7,     dp: 4'b0010, lz: 32'hFFFF_FE1F, nb: 32'h0303_021F, ovf: 1'b0};
    vecs[2] = '{value: 14'd10000, dp: 4'b0000, lz: 32'hFDFD_FDFD, nb: 32'hFDFD_FDFD, ovf: 1'b1};
    vecs[3] = '{value: 14'd9999,  dp: 4'b0000, lz: 32'h0909_0909, nb: 32'h0909_0909, ovf: 1'b0};
    vecs[4] = '{value: 14'd0,     dp: 4'b0000, lz: 32'hFFFF_FF03, nb: 32'h0303_0303, ovf: 1'b0};
    vecs[5] = '{value: 14'd16383, dp: 4'b0000, lz: 32'hFDFD_FDFD, nb: 32'hFDFD_FDFD, ovf: 1'b1};
    vecs[6] = '{value: 14'd1005,  dp: 4'b0000, lz: 32'h9F03_0349, nb: 32'h9F03_0349, ovf: 1'b0};
    vecs[7] = '{value: 14'd50,    dp: 4'b1111, lz: 32'hFEFE_4802, nb: 32'h0202_4802, ovf: 1'b0};

    Reset = 1'b0; Load = 1'b0; Value = '0; Dp_mask = '0;
    repeat (3) @(negedge CLK);
    check_reset_vals("por");
    release_and_check("por_rel");

    foreach (vecs[i]) run_load($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back loads: 42, then 1 and 2 while busy; 2 supersedes 1.
    Dp_mask = '0;
    sb_q.push_back('{lz: 32'hFFFF_9925, nb: 32'h0303_9925, ovf: 1'b0});
    sb_q.push_back('{lz: 32'hFFFF_FF25, nb: 32'h0303_0325, ovf: 1'b0});
    busy_cnt = 0; seen42 = '0; s42 = '1; saw1 = 1'b0;
    @(negedge CLK);
    for (int c = 0; c < 40; c++) begin
      Load = 1'b0;
      if (c == 0) begin Value = 14'd42; Load = 1'b1; end
      if (c == 2) begin Value = 14'd1;  Load = 1'b1; end
      if (c == 5) begin Value = 14'd2;  Load = 1'b1; end
      @(negedge CLK);
      if (busy_a) busy_cnt++;
      if (c == 14) check("pend_busy_no_gap", 32'(busy_a), 32'd1);
      if (c == 27) check("pend_busy_before_commit", 32'(busy_a), 32'd1);
      if (c == 28) check("pend_busy_fall", 32'(busy_a), 32'd0);
      ia = idx_of(an_a);
      if (c >= 15 && c <= 27 && ia >= 0) begin
        s42[ia[1:0]] = seg_a;
        seen42[ia[1:0]] = 1'b1;
      end
      if (ia == 0 && seg_a == 8'h9F) saw1 = 1'b1;
    end
    Load = 1'b0;
    check("pend_busy_cycles", 32'(busy_cnt), 32'd28);
    e = sb_q.pop_front();
    check("pend_42_seen", 32'($countones(seen42) >= 3), 32'd1);
    for (int d = 0; d < 4; d++)
      if (seen42[d]) check($sformatf("pend_42_d%0d", d), 32'(s42[d]), 32'(e.lz[d]));
    e = sb_q.pop_front();
    check_display("pend_2", e.lz, e.nb);
    check("pend_never_1", 32'(saw1), 32'd0);

    // Reset in the middle of a conversion with overflow showing.
    run_load("pre_rst", vecs[2]);
    @(negedge CLK);
    Value = 14'd5555;
    Load  = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    repeat (7) @(negedge CLK);
    check("mid_busy", 32'(busy_a), 32'd1);
    Reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (3) @(negedge CLK);
    check_reset_vals("mid_rst_hold");
    release_and_check("mid_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
